gb_lcd_capture: RTL and testbench
=================================

Name: gb_lcd_capture

Overview:
- Upstream stage of the VGA scan-out. Samples the Game Boy LCD bus (pixel clock, line latch, frame sync, 2-bit pixel data) on the fast system clock.
- Qualifies and debounces the LCD edges, then tracks pixel and line position within each 160x144 frame.
- Emits single-cycle write strobes with a linear address and pixel data for the dual-port framebuffer.
- Reports frame completion, malformed lines and malformed frames.

Parameters:
- H_PIX, 160, pixels per LCD line.
- V_LINES, 144, lines per LCD frame.
- ADDR_W, 15, framebuffer address width.
- SYNC_STAGES, 2, metastability flops on each asynchronous input; minimum 2.

Ports:
- clk  in  1  system (PLL) clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- iclk  in  1  LCD pixel clock, asynchronous to clk.
- ihsync  in  1  LCD line latch, asynchronous.
- ivsync  in  1  LCD frame sync, asynchronous.
- idata  in  2  LCD pixel data, asynchronous.
- wr_addr  out  ADDR_W  framebuffer write address.
- wr_data  out  2  framebuffer write data.
- wr_en  out  1  one-cycle write strobe.
- frame_done  out  1  one-cycle pulse: a complete frame was received.
- line_err  out  1  one-cycle pulse: a line ended with a pixel count other than H_PIX.
- frame_err  out  1  one-cycle pulse: a frame ended with a line count other than V_LINES.
- locked  out  1  high once the first frame sync has been seen.

Behaviour:
- Reset (async assert, sync release): all outputs 0; counters 0; synchronizer and history flops 0; FSM in WAIT_VS.
- Input path:
  - iclk, ihsync, ivsync and idata each pass through SYNC_STAGES flops.
  - Each synchronized strobe feeds a 3-deep history. A qualified rising edge is history == {old 0, 1, newest 1}, i.e. the strobe must be high for 2 consecutive samples after being low.
  - Glitches of 1 clk high produce no edge.
- Data alignment: the captured pixel is the synchronized idata sample taken in the same clk as the first high sample of iclk. idata is delayed by the history depth to achieve this.
- FSM:
  - WAIT_VS: all iclk/ihsync edges are ignored and no errors are raised. A vsync edge sets x=0, y=0, locked=1 and moves to ACTIVE.
  - ACTIVE, vsync edge:
    - if y==V_LINES, pulse frame_done; otherwise pulse frame_err.
    - Then x=0, y=0.
  - ACTIVE, hsync edge:
    - if x!=H_PIX, pulse line_err.
    - Then x=0 and y=y+1, saturating at V_LINES.
  - ACTIVE, iclk edge:
    - if x<H_PIX and y<V_LINES: write pixel and set x=x+1.
    - Otherwise: no write, and x saturates at H_PIX+1 so that the overrun is reported at the next hsync.
- Write timing:
  - wr_en is asserted in the clk after the edge-detect cycle (1-cycle registered latency) and lasts exactly 1 cycle.
  - wr_addr = y*H_PIX + x, using pre-increment x and computed in ADDR_W bits. For the default parameters this is (y<<7)+(y<<5)+x, range 0..23039.
  - wr_addr and wr_data hold their last value when wr_en=0.
- Priority of simultaneous qualified edges in one clk: vsync > hsync > iclk.
  - vsync with hsync: only the frame action occurs; no line_err.
  - Any sync edge with an iclk edge: the pixel is dropped.
- Error pulses coincide with the cycle after the edge, aligned with the wr_en timing.
- Reset mid-frame: everything clears immediately, locked=0, and the FSM returns to WAIT_VS. A pending write strobe is cancelled.
- Maximum input rate: iclk must stay low and high for at least 3 clk each for capture. Faster toggling is out of spec, with no required behaviour beyond not hanging the FSM.

Decomposition:
- Shared package gbvga_pkg holds:
  - GB_H_PIX=160, GB_V_LINES=144, FB_ADDR_W=15.
  - The FSM state enum {WAIT_VS, ACTIVE}.
- The VGA scan-out uses the same GB_* and FB_ADDR_W constants.
- One sub-module: gb_edge_qual. It contains the synchronizer, 3-deep history and qualified-rise output, instantiated three times (iclk, ihsync, ivsync). The idata delay line stays in the top.

Test Plan:
- Reset then 160 iclk pulses + hsync, repeated 144 times, then vsync -> 23040 writes with addresses 0..23039 in order. Data matches the driven pattern (x+y)%4. frame_done pulses once; no line_err or frame_err.
- iclk pulses before the first vsync -> no wr_en and locked=0. After the vsync, locked=1 and the first write goes to address 0.
- Line with 159 pixels then hsync -> line_err pulses once. The next line's first write is at address y*160 with the incremented y.
- Line with 162 pixels -> 160 writes only and line_err at hsync.
- Frame of 143 lines then vsync -> frame_err, no frame_done.
- 1-clk-wide iclk glitch -> no write.
- iclk and hsync qualified in the same clk -> no write, x=0.
- rst_n asserted at line 70, pixel 80 -> outputs 0 immediately. Writes resume only after the next vsync, starting at address 0.

Source files
------------

// File: rtl/gbvga_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : gbvga_pkg
//  Purpose  : Constants and types shared by the Game Boy LCD capture front end
//             and the VGA scan-out (frame geometry, framebuffer address width,
//             capture FSM state encoding).
//  Revision : 1.0  initial release
// ============================================================================
package gbvga_pkg;

  localparam int GB_H_PIX   = 160;
  localparam int GB_V_LINES = 144;
  localparam int FB_ADDR_W  = 15;

  typedef enum logic [0:0] {
    WAIT_VS = 1'b0,
    ACTIVE  = 1'b1
  } cap_state_t;

endpackage
`default_nettype wire

// File: rtl/gb_edge_qual.sv
`default_nettype none
// ============================================================================
//  Module   : gb_edge_qual
//  Purpose  : Brings one asynchronous LCD strobe into the clk domain and
//             reports a qualified rising edge. The strobe must be seen high on
//             two consecutive samples after a low sample; a single-sample
//             glitch never produces an edge.
//  Ports    : clk       system clock
//             rst_n     asynchronous active-low reset
//             async_in  raw asynchronous strobe
//             rise      combinational qualified-rise flag (one clk wide)
//  Revision : 1.0  initial release
// ============================================================================
module gb_edge_qual #(
  parameter int SYNC_STAGES = 2  // must be >= 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  // hist_q[0] is the newest synchronized sample, hist_q[2] the oldest
  logic [2:0]             hist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      hist_q <= {hist_q[1:0], sync_q[SYNC_STAGES-1]};
    end
  end

  assign rise = (hist_q == 3'b011);

endmodule
`default_nettype wire

// File: rtl/gb_lcd_capture.sv
`default_nettype none
// ============================================================================
//  Module   : gb_lcd_capture
//  Purpose  : Samples the Game Boy LCD bus on the system clock, tracks the
//             pixel/line position in each frame and emits single-cycle
//             framebuffer write strobes. Flags short/long lines and frames.
//  Ports    : clk, rst_n            system clock, async active-low reset
//             iclk, ihsync, ivsync  LCD pixel clock, line latch, frame sync
//             idata[1:0]            LCD pixel data
//             wr_addr, wr_data      framebuffer write address / data
//             wr_en                 one-cycle write strobe
//             frame_done            one-cycle pulse, complete frame received
//             line_err              one-cycle pulse, bad pixel count at hsync
//             frame_err             one-cycle pulse, bad line count at vsync
//             locked                high once the first vsync has been seen
//  Revision : 1.0  initial release
// ============================================================================
module gb_lcd_capture
  import gbvga_pkg::*;
#(
  parameter int H_PIX       = GB_H_PIX,
  parameter int V_LINES     = GB_V_LINES,
  parameter int ADDR_W      = FB_ADDR_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              iclk,
  input  logic              ihsync,
  input  logic              ivsync,
  input  logic [1:0]        idata,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [1:0]        wr_data,
  output logic              wr_en,
  output logic              frame_done,
  output logic              line_err,
  output logic              frame_err,
  output logic              locked
);

  // x must reach H_PIX+1 (overrun marker), y must reach V_LINES
  localparam int XW = $clog2(H_PIX + 2);
  localparam int YW = $clog2(V_LINES + 1);
  localparam logic [XW-1:0] X_FULL = XW'(H_PIX);
  localparam logic [XW-1:0] X_OVR  = XW'(H_PIX + 1);
  localparam logic [YW-1:0] Y_FULL = YW'(V_LINES);

  logic pix_rise, hs_rise, vs_rise;

  gb_edge_qual #(.SYNC_STAGES(SYNC_STAGES)) u_clk_qual (
    .clk(clk), .rst_n(rst_n), .async_in(iclk),   .rise(pix_rise));
  gb_edge_qual #(.SYNC_STAGES(SYNC_STAGES)) u_hs_qual (
    .clk(clk), .rst_n(rst_n), .async_in(ihsync), .rise(hs_rise));
  gb_edge_qual #(.SYNC_STAGES(SYNC_STAGES)) u_vs_qual (
    .clk(clk), .rst_n(rst_n), .async_in(ivsync), .rise(vs_rise));

  // Data path: same synchronizer depth as the strobes, then two more flops
  // so data_dly_q[1] lines up with the first high iclk sample at the moment
  // the qualifier fires (that sample sits in the middle history slot).
  logic [1:0] data_sync_q [SYNC_STAGES];
  logic [1:0] data_dly_q  [2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) data_sync_q[i] <= '0;
      data_dly_q[0] <= '0;
      data_dly_q[1] <= '0;
    end else begin
      data_sync_q[0] <= idata;
      for (int i = 1; i < SYNC_STAGES; i++) data_sync_q[i] <= data_sync_q[i-1];
      data_dly_q[0] <= data_sync_q[SYNC_STAGES-1];
      data_dly_q[1] <= data_dly_q[0];
    end
  end

  cap_state_t        state_q, state_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [ADDR_W-1:0] addr_d;
  logic [1:0]        data_d;
  logic              wr_en_d, frame_done_d, line_err_d, frame_err_d, locked_d;
  logic [ADDR_W-1:0] lin_addr;

  assign lin_addr = ADDR_W'(y_q) * ADDR_W'(H_PIX) + ADDR_W'(x_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= WAIT_VS;
      x_q        <= '0;
      y_q        <= '0;
      wr_addr    <= '0;
      wr_data    <= '0;
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      line_err   <= 1'b0;
      frame_err  <= 1'b0;
      locked     <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      wr_addr    <= addr_d;
      wr_data    <= data_d;
      wr_en      <= wr_en_d;
      frame_done <= frame_done_d;
      line_err   <= line_err_d;
      frame_err  <= frame_err_d;
      locked     <= locked_d;
    end
  end

  // Edge priority within one clk: vsync, then hsync, then pixel clock.
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    addr_d       = wr_addr;
    data_d       = wr_data;
    wr_en_d      = 1'b0;
    frame_done_d = 1'b0;
    line_err_d   = 1'b0;
    frame_err_d  = 1'b0;
    locked_d     = locked;
    unique case (state_q)
      WAIT_VS: begin
        if (vs_rise) begin
          x_d      = '0;
          y_d      = '0;
          locked_d = 1'b1;
          state_d  = ACTIVE;
        end
      end
      ACTIVE: begin
        if (vs_rise) begin
          frame_done_d = (y_q == Y_FULL);
          frame_err_d  = (y_q != Y_FULL);
          x_d          = '0;
          y_d          = '0;
        end else if (hs_rise) begin
          line_err_d = (x_q != X_FULL);
          x_d        = '0;
          y_d        = (y_q == Y_FULL) ? y_q : y_q + YW'(1);
        end else if (pix_rise) begin
          if ((x_q < X_FULL) && (y_q < Y_FULL)) begin
            wr_en_d = 1'b1;
            addr_d  = lin_addr;
            data_d  = data_dly_q[1];
            x_d     = x_q + XW'(1);
          end else begin
            // park past the end so the next hsync reports the overrun
            x_d = X_OVR;
          end
        end
      end
      default: state_d = WAIT_VS;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_gb_lcd_capture.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gb_lcd_capture
//  Purpose  : Self-checking bench for gb_lcd_capture. Runs a reduced 40x18
//             geometry so complete frames stay short; the address arithmetic
//             is the same y*H_PIX+x rule. LCD strobes use randomized widths
//             within the legal 3..5 clk high/low window and random pixel data.
//  Revision : 1.0  initial release
// ============================================================================
module tb_gb_lcd_capture;

  localparam int H  = 40;
  localparam int V  = 18;
  localparam int AW = 15;
  localparam int SS = 2;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          iclk = 1'b0, ihsync = 1'b0, ivsync = 1'b0;
  logic [1:0]    idata = 2'b00;
  logic [AW-1:0] wr_addr;
  logic [1:0]    wr_data;
  logic          wr_en, frame_done, line_err, frame_err, locked;

  gb_lcd_capture #(.H_PIX(H), .V_LINES(V), .ADDR_W(AW), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst_n(rst_n), .iclk(iclk), .ihsync(ihsync), .ivsync(ivsync),
    .idata(idata), .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en),
    .frame_done(frame_done), .line_err(line_err), .frame_err(frame_err),
    .locked(locked));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // ---------------- observed events (sampled on falling edge) -------------
  logic [AW+1:0] got_q[$];
  int got_fd = 0, got_le = 0, got_fe = 0, wide_wr = 0;
  logic prev_wr = 1'b0;

  always @(negedge clk) begin
    if (wr_en) got_q.push_back({wr_addr, wr_data});
    if (wr_en && prev_wr) wide_wr++;
    prev_wr = wr_en;
    if (frame_done) got_fd++;
    if (line_err)   got_le++;
    if (frame_err)  got_fe++;
  end

  // ---------------- reference model (event level) --------------------------
  logic [AW+1:0] exp_q[$];
  int exp_fd = 0, exp_le = 0, exp_fe = 0;
  bit m_locked = 1'b0;
  int m_x = 0, m_y = 0;
  logic [AW+1:0] exp_last = '0;

  function automatic void m_pixel(input logic [1:0] d);
    if (!m_locked) return;
    if (m_x < H && m_y < V) begin
      exp_last = {AW'(m_y * H + m_x), d};
      exp_q.push_back(exp_last);
      m_x++;
    end else begin
      m_x = H + 1;
    end
  endfunction

  function automatic void m_hsync();
    if (!m_locked) return;
    if (m_x != H) exp_le++;
    m_x = 0;
    if (m_y < V) m_y++;
  endfunction

  function automatic void m_vsync();
    if (m_locked) begin
      if (m_y == V) exp_fd++;
      else          exp_fe++;
    end
    m_locked = 1'b1;
    m_x = 0;
    m_y = 0;
  endfunction

  function automatic void m_reset();
    m_locked = 1'b0;
    m_x = 0;
    m_y = 0;
    exp_last = '0;
  endfunction

  function automatic int write_mismatches();
    int n = 0;
    if (got_q.size() != exp_q.size()) n++;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] !== exp_q[i]) n++;
    return n;
  endfunction

  // ---------------- stimulus helpers ---------------------------------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic clear_obs();
    got_q.delete(); exp_q.delete();
    got_fd = 0; got_le = 0; got_fe = 0;
    exp_fd = 0; exp_le = 0; exp_fe = 0;
  endtask

  // One LCD event: selected strobes high together, then all low.
  task automatic strobe(input bit c, input bit h, input bit v, input logic [1:0] d);
    idata = d; iclk = c; ihsync = h; ivsync = v;
    tick(3 + int'($urandom_range(0, 2)));
    iclk = 1'b0; ihsync = 1'b0; ivsync = 1'b0; idata = 2'($urandom);
    tick(3 + int'($urandom_range(0, 2)));
    if (v)      m_vsync();
    else if (h) m_hsync();
    else if (c) m_pixel(d);
  endtask

  task automatic send_line(input int n, input int row, input bit pattern);
    for (int x = 0; x < n; x++)
      strobe(1'b1, 1'b0, 1'b0, pattern ? 2'((x + row) % 4) : 2'($urandom));
    strobe(1'b0, 1'b1, 1'b0, 2'b00);
  endtask

  task automatic glitch();
    iclk = 1'b1; tick(1);
    iclk = 1'b0; tick(4);
  endtask

  task automatic check_model(input string name);
    int n;
    tick(10);
    n = write_mismatches();
    checks++;
    if (n !== 0)
      $display("FAIL %s writes: %0d bad entries, got %0d writes, required %0d",
               name, n, got_q.size(), exp_q.size());
    checks++;
    if ({got_fd, got_le, got_fe} !== {exp_fd, exp_le, exp_fe})
      $display("FAIL %s pulses: got fd/le/fe=%0d/%0d/%0d required %0d/%0d/%0d",
               name, got_fd, got_le, got_fe, exp_fd, exp_le, exp_fe);
    if (n !== 0 || {got_fd, got_le, got_fe} !== {exp_fd, exp_le, exp_fe}) errors++;
  endtask

  // ---------------- tests --------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    tick(3);
    checks++;
    if ({wr_addr, wr_data, wr_en, frame_done, line_err, frame_err, locked} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got addr=%0d data=%0d en=%b fd=%b le=%b fe=%b lk=%b required all 0",
               wr_addr, wr_data, wr_en, frame_done, line_err, frame_err, locked);
    end
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_prelock();
    logic [AW-1:0] a0;
    clear_obs();
    for (int i = 0; i < 5; i++) strobe(1'b1, 1'b0, 1'b0, 2'($urandom));
    strobe(1'b0, 1'b1, 1'b0, 2'b00);
    tick(10);
    checks++;
    if (got_q.size() != 0 || locked !== 1'b0 || got_le != 0) begin
      errors++;
      $display("FAIL prelock: got writes=%0d locked=%b line_err=%0d required 0/0/0",
               got_q.size(), locked, got_le);
    end
    strobe(1'b0, 1'b0, 1'b1, 2'b00);
    tick(4);
    checks++;
    if (locked !== 1'b1) begin
      errors++;
      $display("FAIL lock: got locked=%b required 1", locked);
    end
    send_line(H, 0, 1'b0);
    check_model("first_line");
    a0 = (got_q.size() > 0) ? got_q[0][AW+1:2] : '1;
    checks++;
    if (a0 !== '0) begin
      errors++;
      $display("FAIL first_addr: got %0d required 0", a0);
    end
  endtask

  task automatic test_full_frame();
    int bad = 0;
    strobe(1'b0, 1'b0, 1'b1, 2'b00);
    tick(6);
    clear_obs();
    for (int r = 0; r < V; r++) send_line(H, r, 1'b1);
    strobe(1'b0, 1'b0, 1'b1, 2'b00);
    check_model("full_frame");
    for (int i = 0; i < got_q.size(); i++)
      if (got_q[i] !== {AW'(i), 2'(((i % H) + (i / H)) % 4)}) bad++;
    checks++;
    if (got_q.size() != H * V || bad != 0 || got_fd != 1 || got_le != 0 || got_fe != 0) begin
      errors++;
      $display("FAIL full_frame_seq: got writes=%0d bad=%0d fd=%0d le=%0d fe=%0d required %0d/0/1/0/0",
               got_q.size(), bad, got_fd, got_le, got_fe, H * V);
    end
  endtask

  task automatic test_short_line();
    logic [AW-1:0] a;
    clear_obs();
    send_line(H - 1, 0, 1'b0);
    send_line(H, 1, 1'b0);
    check_model("short_line");
    a = (got_q.size() > H - 1) ? got_q[H-1][AW+1:2] : '1;
    checks++;
    if (got_le != 1 || a !== AW'(H)) begin
      errors++;
      $display("FAIL short_line_next: got line_err=%0d next_addr=%0d required 1/%0d",
               got_le, a, H);
    end
  endtask

  task automatic test_long_line();
    clear_obs();
    send_line(H + 2, 2, 1'b0);
    check_model("long_line");
    checks++;
    if (got_q.size() != H || got_le != 1) begin
      errors++;
      $display("FAIL long_line_cnt: got writes=%0d line_err=%0d required %0d/1",
               got_q.size(), got_le, H);
    end
  endtask

  task automatic test_short_frame();
    strobe(1'b0, 1'b0, 1'b1, 2'b00);
    tick(6);
    clear_obs();
    for (int r = 0; r < V - 1; r++) send_line(H, r, 1'b0);
    strobe(1'b0, 1'b0, 1'b1, 2'b00);
    check_model("short_frame");
    checks++;
    if (got_fe != 1 || got_fd != 0) begin
      errors++;
      $display("FAIL short_frame_pulse: got frame_err=%0d frame_done=%0d required 1/0",
               got_fe, got_fd);
    end
  endtask

  task automatic test_glitch();
    clear_obs();
    glitch();
    tick(8);
    checks++;
    if (got_q.size() != 0) begin
      errors++;
      $display("FAIL glitch: got writes=%0d required 0", got_q.size());
    end
    strobe(1'b1, 1'b0, 1'b0, 2'($urandom));
    glitch();
    strobe(1'b1, 1'b0, 1'b0, 2'($urandom));
    check_model("glitch_between");
  endtask

  task automatic test_simultaneous();
    logic [AW-1:0] a;
    int n0;
    strobe(1'b0, 1'b0, 1'b1, 2'b00);
    tick(6);
    clear_obs();
    for (int i = 0; i < 5; i++) strobe(1'b1, 1'b0, 1'b0, 2'($urandom));
    n0 = got_q.size();
    strobe(1'b1, 1'b1, 1'b0, 2'($urandom));
    tick(6);
    checks++;
    if (got_q.size() != n0) begin
      errors++;
      $display("FAIL pix_hs_same_clk: got writes=%0d required %0d", got_q.size(), n0);
    end
    for (int i = 0; i < 3; i++) strobe(1'b1, 1'b0, 1'b0, 2'($urandom));
    check_model("pix_hs_same_clk");
    a = (got_q.size() > 5) ? got_q[5][AW+1:2] : '1;
    checks++;
    if (a !== AW'(H)) begin
      errors++;
      $display("FAIL pix_hs_addr: got %0d required %0d", a, H);
    end
    clear_obs();
    strobe(1'b0, 1'b1, 1'b1, 2'b00);
    check_model("vs_hs_same_clk");
    checks++;
    if (got_le != 0 || got_fe != 1) begin
      errors++;
      $display("FAIL vs_hs_pulse: got line_err=%0d frame_err=%0d required 0/1", got_le, got_fe);
    end
  endtask

  task automatic test_back_to_back();
    clear_obs();
    for (int l = 0; l < 6; l++) begin
      if ($urandom_range(0, 1) == 1) glitch();
      send_line(H - 2 + int'($urandom_range(0, 3)), 0, 1'b0);
    end
    strobe(1'b0, 1'b0, 1'b1, 2'b00);
    send_line(H, 0, 1'b0);
    check_model("random_lines");
  endtask

  task automatic test_reset_mid();
    logic [AW-1:0] a0;
    strobe(1'b0, 1'b0, 1'b1, 2'b00);
    tick(6);
    clear_obs();
    for (int r = 0; r < V / 2; r++) send_line(H, r, 1'b0);
    for (int i = 0; i < H / 2; i++) strobe(1'b1, 1'b0, 1'b0, 2'($urandom));
    check_model("before_reset");
    rst_n = 1'b0;
    m_reset();
    #1;
    checks++;
    if ({wr_addr, wr_data, wr_en, frame_done, line_err, frame_err, locked} !== '0) begin
      errors++;
      $display("FAIL reset_mid: got addr=%0d data=%0d en=%b lk=%b required all 0",
               wr_addr, wr_data, wr_en, locked);
    end
    tick(3);
    rst_n = 1'b1;
    tick(2);
    clear_obs();
    send_line(5, 0, 1'b0);
    strobe(1'b0, 1'b0, 1'b1, 2'b00);
    for (int i = 0; i < 3; i++) strobe(1'b1, 1'b0, 1'b0, 2'($urandom));
    check_model("after_reset");
    a0 = (got_q.size() > 0) ? got_q[0][AW+1:2] : '1;
    checks++;
    if (got_q.size() != 3 || a0 !== '0) begin
      errors++;
      $display("FAIL reset_resume: got writes=%0d first_addr=%0d required 3/0",
               got_q.size(), a0);
    end
  endtask

  task automatic test_hold_and_width();
    tick(5);
    checks++;
    if ({wr_addr, wr_data} !== exp_last || wide_wr != 0) begin
      errors++;
      $display("FAIL hold_width: got addr/data=%0h wide=%0d required %0h/0",
               {wr_addr, wr_data}, wide_wr, exp_last);
    end
  endtask

  initial begin
    test_reset();
    test_prelock();
    test_full_frame();
    test_short_line();
    test_long_line();
    test_short_frame();
    test_glitch();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid();
    test_hold_and_width();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
